fc8_input_controller: RTL

FC8_INPUT_CONTROLLER -- requirements
Module: fc8_input_controller

---
 rtl/fc8_input_controller_if.sv | 34 +++
 rtl/fc8_input_controller.sv | 118 +++++++++++
 2 files changed

// File: rtl/fc8_input_controller_if.sv
// Gamepad poll controller bundle: poll control, serial pad pins and button status.
// slave = controller side, master = system/pad side.
interface fc8_input_controller_if;
    logic       enable;
    logic       poll_now;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic [7:0] input_status_out;
    logic       status_valid;
    logic       busy;

    modport slave (
        input  enable,
        input  poll_now,
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output input_status_out,
        output status_valid,
        output busy
    );

    modport master (
        output enable,
        output poll_now,
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  input_status_out,
        input  status_valid,
        input  busy
    );
endinterface

// File: rtl/fc8_input_controller.sv
// Polls an 8-button serial gamepad (latch, then 8 clocked bits) periodically or on demand; 18*CLK_DIV+1 cycles poll-start to status_valid.
// No backpressure: status is published as a one-cycle pulse; poll requests while busy are dropped, not queued.
module fc8_input_controller #(
    parameter int CLK_DIV       = 16,
    parameter int POLL_INTERVAL = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fc8_input_controller_if.slave   pad_if
);

    localparam int TW = $clog2(2 * CLK_DIV + 1);
    localparam int CW = $clog2(POLL_INTERVAL + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(CLK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(POLL_INTERVAL - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_tick, w_tick_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_pad_latch, r_pad_clk, r_valid, r_busy;
    logic [7:0]      r_status;
    logic            w_start, w_load;

    assign w_start = (r_state == IDLE) && pad_if.enable &&
                     ((r_cnt == CNT_LAST) || pad_if.poll_now);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = LATCH;
                    w_tick_nxt  = '0;
                end
            end
            LATCH: begin
                if (r_tick == TICK_LAST) begin
                    w_state_nxt = SHIFT;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_tick_nxt = r_tick + TW'(1);
                end
            end
            SHIFT: begin
                // Sample just before pad_clk rises; pad_data is active-low.
                if (r_tick == TICK_HALF)
                    w_shift_nxt[r_bit] = ~pad_if.pad_data;
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
                    if (r_bit == 3'd7)
                        w_state_nxt = DONE;
                    else
                        w_bit_nxt = r_bit + 3'd1;
                end else begin
                    w_tick_nxt = r_tick + TW'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_load      = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Interval keeps running through a poll so poll starts stay POLL_INTERVAL apart.
    always_comb begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (!pad_if.enable || w_start || (r_cnt == CNT_LAST))
            w_cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_cnt       <= '0;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_status    <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            // Pin strobes come from next-state decode so they are clean flop outputs.
            r_pad_latch <= (w_state_nxt == LATCH);
            r_pad_clk   <= (w_state_nxt == SHIFT) && (w_tick_nxt >= TICK_MID);
            r_busy      <= (w_state_nxt != IDLE);
            r_valid     <= w_load;
            if (w_load)
                r_status <= r_shift;
        end
    end

    assign pad_if.pad_latch        = r_pad_latch;
    assign pad_if.pad_clk          = r_pad_clk;
    assign pad_if.input_status_out = r_status;
    assign pad_if.status_valid     = r_valid;
    assign pad_if.busy             = r_busy;

endmodule
